fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage between the program counter and the IF/ID pipeline register. Drives `pc_write` to the PC register and sends one instruction-memory request at a time. It captures the returned instruction with its PC into the IF/ID register. Redirects from branch, jump and jump-return selection (`flush`) discard wrong-path instructions, and decode stalls are absorbed by a one-entry hold buffer.

## Interface
- `NOP_INSTR`, default `32'h0000_0013`: instruction word placed in IF/ID on reset or flush.
- `clk` input 1: single clock; all state updates on posedge.
- `reset_n` input 1: synchronous, active-low reset.
- `pc_current` input 32: current PC from the PC register.
- `flush` input 1: redirect taken this cycle (OR of branch, jump and jump-return pcSrc).
- `id_stall` input 1: decode cannot accept a new instruction this cycle.
- `imem_req` output 1: request valid.
- `imem_addr` output 32: request address, equal to `pc_current`.
- `imem_ready` input 1: memory accepts the request this cycle.
- `imem_rvalid` input 1: response valid.
- `imem_rdata` input 32: response instruction.
- `pc_write` output 1: PC register loads `pc_next`.
- `if_id_valid` output 1: IF/ID holds a valid instruction.
- `if_id_pc` output 32: PC of the IF/ID instruction.
- `if_id_instr` output 32: IF/ID instruction word.

## Operation
- Internal state: FSM {REQ, WAIT, DROP, HOLD}, `req_pc[31:0]`, `hold_valid`, `hold_pc`, `hold_instr`.
- At most one memory request is outstanding at any time.
- **REQ**
  - `imem_req = !flush`.
  - If `imem_ready && !flush`: `req_pc <= pc_current`, `pc_write = 1`, go to WAIT.
- **WAIT**
  - `imem_req = 0`.
  - On `imem_rvalid && !flush`: deliver `{req_pc, imem_rdata}`, go to REQ.
  - On `imem_rvalid && flush`: discard the response, go to REQ.
  - On `flush` without `imem_rvalid`: go to DROP.
- **DROP**
  - `imem_req = 0`.
  - On `imem_rvalid`: discard the response, go to REQ.
- **HOLD**
  - `imem_req = 0`.
  - If `!id_stall`: move the hold entry into IF/ID, clear `hold_valid`, go to REQ.
- **Flush in any state**
  - `pc_write = 1` so the PC loads the redirect target.
  - `hold_valid <= 0`.
  - IF/ID is cleared.
  - The next state follows the per-state rules above; from HOLD the next state is REQ.
- **Deliver**
  - If `!if_id_valid || !id_stall`: load IF/ID, `if_id_valid <= 1`.
  - Otherwise: load the hold buffer, `hold_valid <= 1`, go to HOLD instead of REQ.
- **IF/ID update priority**
  1. Reset.
  2. Flush: `if_id_valid <= 0`, `if_id_instr <= NOP_INSTR`, `if_id_pc` unchanged.
  3. Load.
  4. `id_stall && if_id_valid`: hold.
  5. Otherwise: `if_id_valid <= 0`, consumed.
- `pc_write` is a Mealy output, asserted only when a request is accepted or on `flush`. It is never asserted in DROP or HOLD except on flush.
- Reset values:
  - State REQ.
  - `imem_req = 0` and `pc_write = 0` while `reset_n = 0`.
  - `if_id_valid = 0`, `if_id_pc = 0`, `if_id_instr = NOP_INSTR`.
  - `hold_valid = 0`, `req_pc = 0`.
  - Any outstanding response arriving after reset is ignored, because REQ ignores `imem_rvalid`.

## Timing
- Request acceptance is sampled at posedge when `imem_req && imem_ready`.
- Earliest response is the cycle after acceptance; latency is unbounded.
- Best-case throughput is one instruction per 2 cycles (REQ, WAIT).
- Instruction visible on `if_id_*`:
  - 1 cycle after the `imem_rvalid` edge when IF/ID is free.
  - Otherwise 1 cycle after `id_stall` falls.
- `flush` takes effect in the same cycle:
  - `pc_write` and `imem_req` respond combinationally.
  - IF/ID and the hold buffer clear at the next edge.
- `flush` and `imem_rvalid` in the same cycle: the response is dropped.
- `flush` and `imem_ready` in the same cycle: no request is issued.
- `id_stall` and `flush` together: flush wins.
- Buffering bound: one IF/ID entry plus one hold entry; REQ is re-entered only after the hold buffer empties.

## Test plan
- **Single fetch:** `pc_current = 0x100`, `imem_ready = 1`, `imem_rvalid` one cycle later with `0x00500093`.
  - `pc_write` pulses once.
  - Next cycle: `if_id_valid = 1`, `if_id_pc = 0x100`, `if_id_instr = 0x00500093`.
- **Slow memory:** `imem_ready` low for 3 cycles, then response latency 4.
  - `pc_write` is asserted only in the accept cycle.
  - `imem_req` is low throughout WAIT.
  - One IF/ID load, with the correct PC.
- **Stall with response:** IF/ID valid, `id_stall = 1` for 5 cycles, response arrives.
  - FSM enters HOLD; `if_id_*` is unchanged.
  - After `id_stall` falls, IF/ID shows the held instruction the next cycle.
  - No request is issued while in HOLD.
- **Flush in WAIT:** `flush` pulses, response `0xDEADBEEF` arrives 2 cycles later.
  - `pc_write = 1` in the flush cycle.
  - IF/ID becomes invalid with `NOP_INSTR`.
  - `0xDEADBEEF` never appears; the next request uses the new `pc_current`.
- **Flush in HOLD and coincident flush/rvalid:**
  - Hold buffer and IF/ID are cleared.
  - State returns to REQ.
  - Response is dropped.
- **Reset:** `reset_n = 0` while in WAIT, then release.
  - All outputs are at their reset values.
  - A late `imem_rvalid` is ignored.
  - The first request is issued from REQ on the first cycle after release.

Source files
------------

// File: rtl/fetch_stage.sv
// fetch_stage - instruction fetch between the PC register and IF/ID.
//
// Issues one instruction-memory request at a time from pc_current.
// It captures the response together with its PC into the IF/ID register.
// A flush (redirect) discards wrong-path responses. A one-entry hold buffer
// absorbs a response that arrives while decode is stalled on a valid IF/ID.
//
// Ports:
//   clk, reset_n       clock, synchronous active-low reset
//   pc_current         current PC; also the request address
//   flush              redirect taken this cycle
//   id_stall           decode cannot accept a new instruction
//   imem_req/addr      request valid / address (one outstanding max)
//   imem_ready         memory accepts the request this cycle
//   imem_rvalid/rdata  response valid / instruction word
//   pc_write           PC register loads its next value
//   if_id_valid/pc/instr  IF/ID pipeline register contents
module fetch_stage #(
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] pc_current,
    input  logic        flush,
    input  logic        id_stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        pc_write,
    output logic        if_id_valid,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_instr
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    state_t      state, state_next;
    logic [31:0] req_pc;
    logic        hold_valid;
    logic [31:0] hold_pc;
    logic [31:0] hold_instr;

    logic        accept;       // request handed to memory this cycle
    logic        load_if_id;   // IF/ID takes load_pc/load_instr
    logic        load_hold;    // response parked in the hold buffer
    logic        hold_release; // hold entry moves into IF/ID
    logic [31:0] load_pc;
    logic [31:0] load_instr;

    assign imem_addr = pc_current;

    always_comb begin
        state_next   = state;
        imem_req     = 1'b0;
        pc_write     = 1'b0;
        accept       = 1'b0;
        load_if_id   = 1'b0;
        load_hold    = 1'b0;
        hold_release = 1'b0;
        load_pc      = req_pc;
        load_instr   = imem_rdata;

        case (state)
            S_REQ: begin
                imem_req = !flush;
                if (imem_ready && !flush) begin
                    accept     = 1'b1;
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    state_next = S_REQ;
                    if (!flush) begin
                        // Deliver: IF/ID if it is free or being consumed,
                        // otherwise park in the hold buffer.
                        if (!if_id_valid || !id_stall) begin
                            load_if_id = 1'b1;
                        end else begin
                            load_hold  = 1'b1;
                            state_next = S_HOLD;
                        end
                    end
                end else if (flush) begin
                    state_next = S_DROP;
                end
            end
            S_DROP: begin
                if (imem_rvalid) begin
                    state_next = S_REQ;
                end
            end
            S_HOLD: begin
                if (flush) begin
                    state_next = S_REQ;
                end else if (!id_stall) begin
                    hold_release = 1'b1;
                    load_if_id   = 1'b1;
                    load_pc      = hold_pc;
                    load_instr   = hold_instr;
                    state_next   = S_REQ;
                end
            end
            default: state_next = S_REQ;
        endcase

        pc_write = accept || flush;

        // Nothing leaves the stage while reset is held.
        if (!reset_n) begin
            imem_req = 1'b0;
            pc_write = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= S_REQ;
            req_pc <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                req_pc <= pc_current;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n || flush) begin
            hold_valid <= 1'b0;
            if (!reset_n) begin
                hold_pc    <= '0;
                hold_instr <= '0;
            end
        end else if (load_hold) begin
            hold_valid <= 1'b1;
            hold_pc    <= req_pc;
            hold_instr <= imem_rdata;
        end else if (hold_release) begin
            hold_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            if_id_valid <= 1'b0;
            if_id_pc    <= '0;
            if_id_instr <= NOP_INSTR;
        end else if (flush) begin
            if_id_valid <= 1'b0;
            if_id_instr <= NOP_INSTR;
        end else if (load_if_id) begin
            if_id_valid <= 1'b1;
            if_id_pc    <= load_pc;
            if_id_instr <= load_instr;
        end else if (!(id_stall && if_id_valid)) begin
            if_id_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage. Inputs change 1 ns after posedge; outputs
// are checked 1 ns after the inputs settle, well before the next edge.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] pc_current;
    logic        flush;
    logic        id_stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        pc_write;
    logic        if_id_valid;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_instr;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    localparam logic [31:0] NOP = 32'h0000_0013;

    fetch_stage #(.NOP_INSTR(NOP)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .pc_current  (pc_current),
        .flush       (flush),
        .id_stall    (id_stall),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .pc_write    (pc_write),
        .if_id_valid (if_id_valid),
        .if_id_pc    (if_id_pc),
        .if_id_instr (if_id_instr)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic check_ifid(input string tag, input logic v, input logic [31:0] pc, input logic [31:0] ins);
        check_eq({tag, ".valid"}, {31'b0, if_id_valid}, {31'b0, v});
        check_eq({tag, ".pc"}, if_id_pc, pc);
        check_eq({tag, ".instr"}, if_id_instr, ins);
    endtask

    task automatic check_ctl(input string tag, input logic req, input logic pcw);
        check_eq({tag, ".imem_req"}, {31'b0, imem_req}, {31'b0, req});
        check_eq({tag, ".pc_write"}, {31'b0, pc_write}, {31'b0, pcw});
    endtask

    initial begin
        reset_n = 1'b0; pc_current = 32'h100; flush = 1'b0; id_stall = 1'b0;
        imem_ready = 1'b1; imem_rvalid = 1'b0; imem_rdata = '0;

        // Reset
        settle();
        check_ctl("rst_comb", 1'b0, 1'b0);
        step();
        check_ifid("rst", 1'b0, 32'h0, NOP);

        // Single fetch
        reset_n = 1'b1;
        settle();
        check_ctl("single_req", 1'b1, 1'b1);
        check_eq("single_addr", imem_addr, 32'h100);
        step();
        imem_ready = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0050_0093;
        settle();
        check_ctl("single_wait", 1'b0, 1'b0);
        step();
        imem_rvalid = 1'b0;
        check_ifid("single", 1'b1, 32'h100, 32'h0050_0093);

        // Slow memory: ready low 3 cycles, then latency 4
        pc_current = 32'h104;
        for (int i = 0; i < 3; i++) begin
            settle();
            check_ctl("slow_notready", 1'b1, 1'b0);
            step();
        end
        check_eq("slow_consumed", {31'b0, if_id_valid}, 32'h0);
        imem_ready = 1'b1;
        settle();
        check_ctl("slow_accept", 1'b1, 1'b1);
        step();
        imem_ready = 1'b1; pc_current = 32'h200;
        for (int i = 0; i < 3; i++) begin
            settle();
            check_ctl("slow_wait", 1'b0, 1'b0);
            step();
        end
        imem_rvalid = 1'b1; imem_rdata = 32'h00A0_0113;
        step();
        imem_rvalid = 1'b0;
        check_ifid("slow", 1'b1, 32'h104, 32'h00A0_0113);

        // Stall with response -> HOLD
        id_stall = 1'b1; pc_current = 32'h108; imem_ready = 1'b1;
        settle();
        check_ctl("stall_accept", 1'b1, 1'b1);
        step();
        imem_rvalid = 1'b1; imem_rdata = 32'h0020_8193;
        step();
        imem_rvalid = 1'b0;
        check_ifid("stall_held", 1'b1, 32'h104, 32'h00A0_0113);
        for (int i = 0; i < 3; i++) begin
            settle();
            check_ctl("stall_hold", 1'b0, 1'b0);
            step();
        end
        check_ifid("stall_held2", 1'b1, 32'h104, 32'h00A0_0113);
        id_stall = 1'b0;
        settle();
        check_ctl("stall_release", 1'b0, 1'b0);
        step();
        check_ifid("stall_out", 1'b1, 32'h108, 32'h0020_8193);

        // Flush in WAIT
        id_stall = 1'b1; pc_current = 32'h10C;
        step();
        imem_ready = 1'b0;
        check_ifid("flw_kept", 1'b1, 32'h108, 32'h0020_8193);
        flush = 1'b1; pc_current = 32'h300;
        settle();
        check_ctl("flw_flush", 1'b0, 1'b1);
        step();
        flush = 1'b0; id_stall = 1'b0;
        check_ifid("flw_cleared", 1'b0, 32'h108, NOP);
        settle();
        check_ctl("flw_drop", 1'b0, 1'b0);
        step();
        imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        step();
        imem_rvalid = 1'b0; imem_ready = 1'b1;
        check_ifid("flw_discard", 1'b0, 32'h108, NOP);
        settle();
        check_ctl("flw_newreq", 1'b1, 1'b1);
        check_eq("flw_addr", imem_addr, 32'h300);
        step();
        imem_rvalid = 1'b1; imem_rdata = 32'h0000_0513;
        step();
        imem_rvalid = 1'b0;
        check_ifid("flw_new", 1'b1, 32'h300, 32'h0000_0513);

        // Flush in HOLD
        id_stall = 1'b1; pc_current = 32'h304;
        step();
        imem_rvalid = 1'b1; imem_rdata = 32'h1111_1111;
        step();
        imem_rvalid = 1'b0;
        check_ifid("flh_hold", 1'b1, 32'h300, 32'h0000_0513);
        flush = 1'b1;
        settle();
        check_ctl("flh_flush", 1'b0, 1'b1);
        step();
        flush = 1'b0; id_stall = 1'b0; pc_current = 32'h400;
        check_ifid("flh_cleared", 1'b0, 32'h300, NOP);
        settle();
        check_ctl("flh_req", 1'b1, 1'b1);
        step();
        check_ifid("flh_nohold", 1'b0, 32'h300, NOP);

        // Coincident flush and rvalid in WAIT
        flush = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'h2222_2222; imem_ready = 1'b0;
        settle();
        check_ctl("coin_flush", 1'b0, 1'b1);
        step();
        flush = 1'b0; imem_rvalid = 1'b0;
        check_ifid("coin_drop", 1'b0, 32'h300, NOP);
        settle();
        check_ctl("coin_req", 1'b1, 1'b0);

        // Flush with ready in REQ issues nothing
        flush = 1'b1; imem_ready = 1'b1;
        settle();
        check_ctl("flr_flush", 1'b0, 1'b1);
        step();
        flush = 1'b0; imem_ready = 1'b0;
        settle();
        check_ctl("flr_still_req", 1'b1, 1'b0);

        // Reset while in WAIT, late response ignored
        imem_ready = 1'b1; pc_current = 32'h500;
        step();
        imem_ready = 1'b0;
        reset_n = 1'b0;
        settle();
        check_ctl("rstw_comb", 1'b0, 1'b0);
        step();
        reset_n = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'h3333_3333;
        check_ifid("rstw", 1'b0, 32'h0, NOP);
        settle();
        check_ctl("rstw_req", 1'b1, 1'b0);
        check_eq("rstw_addr", imem_addr, 32'h500);
        step();
        imem_rvalid = 1'b0;
        check_ifid("rstw_late", 1'b0, 32'h0, NOP);
        imem_ready = 1'b1;
        settle();
        check_ctl("rstw_first", 1'b1, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
